// File: rtl/spi_rect_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_rect_fill                                                |
// | Description : Solid-colour rectangle engine for the SPI display path.      |
// |               One start pulse sends CASET (0x2A) + x window, RASET (0x2B)  |
// |               + y window, RAMWR (0x2C), then one RGB565 colour per pixel,  |
// |               MSB first, one bit per clock, and finishes with a done pulse.|
// | Ports       : i_clk, i_rst (sync, active-low)                              |
// |               i_start, i_x0/i_x1, i_y0/i_y1 (inclusive), i_color (RGB565)  |
// |               o_mosi, o_dc (0=cmd), o_cs (active-low), o_busy,             |
// |               o_done (1-cycle), o_err (1-cycle, with o_done on reject)     |
// | Options     : SPI_RECT_BYTE_GAP_EN - one idle cycle after every byte       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_rect_fill #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [8:0]  i_x0,
  input  logic [8:0]  i_x1,
  input  logic [8:0]  i_y0,
  input  logic [8:0]  i_y1,
  input  logic [15:0] i_color,
  output logic        o_mosi,
  output logic        o_dc,
  output logic        o_cs,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [7:0] c_CASET  = 8'h2A;
  localparam logic [7:0] c_RASET  = 8'h2B;
  localparam logic [7:0] c_RAMWR  = 8'h2C;
  localparam logic [9:0] c_WIDTH  = 10'(WIDTH);
  localparam logic [9:0] c_HEIGHT = 10'(HEIGHT);
`ifdef SPI_RECT_BYTE_GAP_EN
  localparam logic       c_GAP    = 1'b1;
`else
  localparam logic       c_GAP    = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PIX  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t      r_state;
  logic [8:0]  r_x0, r_x1, r_y0, r_y1;
  logic [15:0] r_color;
  logic [3:0]  r_idx;     // header byte currently on the wire
  logic [7:0]  r_byte;    // byte currently on the wire
  logic [2:0]  r_bit;     // bit position of r_byte currently on o_mosi
  logic        r_gap;     // inside the inter-byte idle cycle
  logic        r_half;    // 0 = colour high byte on the wire, 1 = low byte
  logic [8:0]  r_col, r_row;
  logic        r_mosi, r_dc, r_cs, r_busy, r_done, r_err;

  logic        w_invalid;
  logic        w_enter_gap;
  logic        w_adv;
  logic [7:0]  w_nbyte;
  logic        w_ndc;
  logic        w_last;

  assign w_invalid = (i_x0 > i_x1) || (i_y0 > i_y1) ||
                     ({1'b0, i_x1} >= c_WIDTH) || ({1'b0, i_y1} >= c_HEIGHT);

  // With the gap enabled, a byte's last bit is followed by one idle cycle and
  // the next byte is loaded only when that idle cycle ends.
  assign w_enter_gap = c_GAP && (r_bit == 3'd0) && !r_gap;
  assign w_adv       = c_GAP ? r_gap : (r_bit == 3'd0);

  // Byte that follows the one currently on the wire.
  always_comb begin
    w_nbyte = r_color[15:8];
    w_ndc   = 1'b1;
    w_last  = 1'b0;
    if (r_state == S_HDR) begin
      case (r_idx)
        4'd0:    w_nbyte = {7'd0, r_x0[8]};
        4'd1:    w_nbyte = r_x0[7:0];
        4'd2:    w_nbyte = {7'd0, r_x1[8]};
        4'd3:    w_nbyte = r_x1[7:0];
        4'd4:    begin w_nbyte = c_RASET; w_ndc = 1'b0; end
        4'd5:    w_nbyte = {7'd0, r_y0[8]};
        4'd6:    w_nbyte = r_y0[7:0];
        4'd7:    w_nbyte = {7'd0, r_y1[8]};
        4'd8:    w_nbyte = r_y1[7:0];
        4'd9:    begin w_nbyte = c_RAMWR; w_ndc = 1'b0; end
        default: w_nbyte = r_color[15:8];
      endcase
    end else if (!r_half) begin
      w_nbyte = r_color[7:0];
    end else begin
      w_last = (r_col == r_x1) && (r_row == r_y1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_bit   <= '0;
      r_gap   <= 1'b0;
      r_half  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_mosi  <= 1'b0;
      r_dc    <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (i_start) begin
            if (w_invalid) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_x0    <= i_x0;
              r_x1    <= i_x1;
              r_y0    <= i_y0;
              r_y1    <= i_y1;
              r_color <= i_color;
              r_state <= S_HDR;
              r_idx   <= '0;
              r_byte  <= c_CASET;
              r_bit   <= 3'd7;
              r_gap   <= 1'b0;
              r_cs    <= 1'b0;
              r_busy  <= 1'b1;
              r_dc    <= 1'b0;
              r_mosi  <= c_CASET[7];
            end
          end
        end
        S_HDR, S_PIX: begin
          if (w_enter_gap) begin
            r_gap  <= 1'b1;
            r_mosi <= 1'b0;
          end else if (w_adv) begin
            r_gap <= 1'b0;
            if (w_last) begin
              r_state <= S_END;
              r_cs    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_mosi  <= 1'b0;
              r_dc    <= 1'b0;
            end else begin
              r_byte <= w_nbyte;
              r_mosi <= w_nbyte[7];
              r_dc   <= w_ndc;
              r_bit  <= 3'd7;
              if (r_state == S_HDR) begin
                if (r_idx == 4'd10) begin
                  r_state <= S_PIX;
                  r_half  <= 1'b0;
                  r_col   <= r_x0;
                  r_row   <= r_y0;
                end else begin
                  r_idx <= r_idx + 4'd1;
                end
              end else begin
                r_half <= ~r_half;
                // Column/row walk advances once per finished pixel.
                if (r_half) begin
                  if (r_col == r_x1) begin
                    r_col <= r_x0;
                    r_row <= r_row + 9'd1;
                  end else begin
                    r_col <= r_col + 9'd1;
                  end
                end
              end
            end
          end else begin
            r_bit  <= r_bit - 3'd1;
            r_mosi <= r_byte[r_bit - 3'd1];
          end
        end
        S_END: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mosi = r_mosi;
  assign o_dc   = r_dc;
  assign o_cs   = r_cs;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule
`default_nettype wire
